uart_cmd_responder: RTL and testbench
=====================================

UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clocks allowed between bytes of one command before the command is abandoned.
REQ-002 SHALL have parameter CNT_W, default 16: width of the timeout counter; TIMEOUT_CYCLES SHALL be less than 2^CNT_W.
REQ-003 clk  input  1  clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx_data  input  8  received byte from the UART receiver; valid when rx_done=1.
REQ-006 rx_done  input  1  one-cycle strobe: new received byte.
REQ-007 rx_perr  input  1  parity error for the byte on rx_data; qualified by rx_done.
REQ-008 tx_data  output  8  byte to transmit; held stable from tx_en until tx_done.
REQ-009 tx_en  output  1  one-cycle transmit request to the UART transmitter.
REQ-010 tx_busy  input  1  transmitter busy.
REQ-011 tx_done  input  1  one-cycle strobe: transmission complete.
REQ-012 reg_addr  output  8  register bus address.
REQ-013 reg_wdata  output  8  register bus write data.
REQ-014 reg_we  output  1  one-cycle write strobe.
REQ-015 reg_re  output  1  one-cycle read strobe.
REQ-016 reg_rdata  input  8  read data, valid exactly 1 cycle after reg_re.
REQ-017 timeout  output  1  one-cycle pulse: partial command abandoned.
REQ-018 rx_drop  output  1  one-cycle pulse: byte received while not accepting input, then discarded.

Function
REQ-019 Protocol SHALL be: write = 0x57, addr, data, answered with 0x4B; read = 0x52, addr, answered with reg[addr]. Any other command byte SHALL be answered with 0x3F.
REQ-020 FSM states SHALL be IDLE, GET_ADDR, GET_DATA, REG_WR, REG_RD, RD_CAP, SEND, WAIT_DONE.
REQ-021 IDLE: on rx_done with rx_perr=0:
- 0x57 or 0x52: latch the command and go to GET_ADDR.
- any other value: load tx_data=0x3F and go to SEND.
REQ-022 GET_ADDR: on a valid rx_done, latch reg_addr. Write command goes to GET_DATA; read command goes to REG_RD.
REQ-023 GET_DATA: on a valid rx_done, latch reg_wdata and go to REG_WR.
REQ-024 REG_WR: assert reg_we for exactly one cycle, load tx_data=0x4B, go to SEND.
REQ-025 REG_RD: assert reg_re for exactly one cycle, go to RD_CAP. RD_CAP: load tx_data=reg_rdata, go to SEND.
REQ-026 SEND: assert tx_en for one cycle in the first cycle with tx_busy=0, then go to WAIT_DONE. Otherwise stay in SEND with tx_en=0.
REQ-027 WAIT_DONE: stay until tx_done=1, then go to IDLE.
REQ-028 Any rx_done with rx_perr=1 in IDLE, GET_ADDR or GET_DATA SHALL abandon the command, load tx_data=0x21 and go to SEND. No register strobe is issued.
REQ-029 Timeout counter:
- cleared on every rx_done, and held at 0 outside GET_ADDR/GET_DATA.
- increments each cycle in GET_ADDR/GET_DATA.
- on reaching TIMEOUT_CYCLES-1: pulse timeout for one cycle, go to IDLE, send no response.
REQ-030 If rx_done and the timeout terminal count occur in the same cycle, the byte SHALL win: it is processed and no timeout pulse occurs.
REQ-031 rx_done in REG_WR, REG_RD, RD_CAP, SEND or WAIT_DONE SHALL pulse rx_drop for one cycle; the byte is discarded.
REQ-032 Latency:
- valid data byte at cycle N -> reg_we at N+1 -> earliest tx_en at N+2.
- valid addr byte of a read at cycle N -> reg_re at N+1 -> tx_data captured at N+2 -> earliest tx_en at N+3.
REQ-033 reg_addr and reg_wdata SHALL hold their last latched values between commands.
REQ-034 There SHALL be at most one outstanding response; no input byte is buffered.

Reset
REQ-035 On rst: state=IDLE, tx_en=0, reg_we=0, reg_re=0, timeout=0, rx_drop=0, tx_data=0x00, reg_addr=0x00, reg_wdata=0x00, counter=0.
REQ-036 rst SHALL take priority over all other inputs.
REQ-037 rst asserted mid-command or mid-response SHALL discard the command, issue no further strobes, and not wait for tx_done.

Verification
REQ-038 Bytes 0x57,0x10,0xA5 with tx_busy=0 -> one reg_we with addr 0x10, wdata 0xA5; tx_en with tx_data 0x4B one cycle later.
REQ-039 Bytes 0x52,0x22 with reg_rdata=0x5C -> reg_re with addr 0x22; tx_en with tx_data 0x5C at N+3; tx_done returns FSM to IDLE.
REQ-040 Byte 0x41 -> tx_data 0x3F sent. Bytes 0x57 then 0x10 with rx_perr=1 -> tx_data 0x21 sent, no reg_we.
REQ-041 TIMEOUT_CYCLES=8; byte 0x52 then 8 idle cycles -> timeout pulses once, no tx_en. Repeat with a byte at the terminal cycle -> no timeout.
REQ-042 tx_busy held high 20 cycles in SEND -> tx_en deferred to the first cycle with tx_busy=0. rx_done during WAIT_DONE -> rx_drop pulses once.
REQ-043 rst asserted in GET_DATA after 0x57,0x10 -> all outputs at reset values next cycle; a subsequent 0x52,0x10 completes normally.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// Byte-command responder: turns UART write/read commands into register bus strobes
// and sends back one response byte per command.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_perr,
    output logic [7:0] tx_data,
    output logic       tx_en,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       timeout,
    output logic       rx_drop
);

    localparam logic [7:0] CmdWrite  = 8'h57;
    localparam logic [7:0] CmdRead   = 8'h52;
    localparam logic [7:0] RespAck   = 8'h4B;
    localparam logic [7:0] RespBad   = 8'h3F;
    localparam logic [7:0] RespPerr  = 8'h21;
    localparam logic [CNT_W-1:0] CntTerm = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StRegWr,
        StRegRd,
        StRdCap,
        StSend,
        StWaitDone
    } state_e;

    state_e           state_q, state_d;
    logic             is_wr_q, is_wr_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rx_ok;
    logic rx_bad;
    logic in_get;
    logic cnt_term;
    logic tx_en_c, we_c, re_c, timeout_c, drop_c;

    assign rx_ok    = rx_done & ~rx_perr;
    assign rx_bad   = rx_done & rx_perr;
    assign in_get   = (state_q == StGetAddr) || (state_q == StGetData);
    assign cnt_term = in_get && (cnt_q == CntTerm);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            is_wr_q   <= 1'b0;
            tx_data_q <= 8'h00;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            tx_data_q <= tx_data_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
        end
    end

    // A byte arriving on the terminal count is processed; the timeout only fires without one.
    always_comb begin
        cnt_d = '0;
        if (in_get && !rx_done && !cnt_term) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        tx_data_d = tx_data_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_en_c   = 1'b0;
        we_c      = 1'b0;
        re_c      = 1'b0;
        timeout_c = 1'b0;
        drop_c    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_bad) begin
                    tx_data_d = RespPerr;
                    state_d   = StSend;
                end else if (rx_ok) begin
                    if (rx_data == CmdWrite || rx_data == CmdRead) begin
                        is_wr_d = (rx_data == CmdWrite);
                        state_d = StGetAddr;
                    end else begin
                        tx_data_d = RespBad;
                        state_d   = StSend;
                    end
                end
            end
            StGetAddr: begin
                if (rx_bad) begin
                    tx_data_d = RespPerr;
                    state_d   = StSend;
                end else if (rx_ok) begin
                    addr_d  = rx_data;
                    state_d = is_wr_q ? StGetData : StRegRd;
                end else if (cnt_term) begin
                    timeout_c = 1'b1;
                    state_d   = StIdle;
                end
            end
            StGetData: begin
                if (rx_bad) begin
                    tx_data_d = RespPerr;
                    state_d   = StSend;
                end else if (rx_ok) begin
                    wdata_d = rx_data;
                    state_d = StRegWr;
                end else if (cnt_term) begin
                    timeout_c = 1'b1;
                    state_d   = StIdle;
                end
            end
            StRegWr: begin
                we_c      = 1'b1;
                drop_c    = rx_done;
                tx_data_d = RespAck;
                state_d   = StSend;
            end
            StRegRd: begin
                re_c    = 1'b1;
                drop_c  = rx_done;
                state_d = StRdCap;
            end
            StRdCap: begin
                drop_c    = rx_done;
                tx_data_d = reg_rdata;
                state_d   = StSend;
            end
            StSend: begin
                drop_c = rx_done;
                if (!tx_busy) begin
                    tx_en_c = 1'b1;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                drop_c = rx_done;
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are decoded from the current state, so reset must mask them in its own cycle.
    assign tx_en     = tx_en_c & ~rst;
    assign reg_we    = we_c & ~rst;
    assign reg_re    = re_c & ~rst;
    assign timeout   = timeout_c & ~rst;
    assign rx_drop   = drop_c & ~rst;
    assign tx_data   = tx_data_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench: the driver queues expected strobes with their cycle, a negedge
// monitor pops and compares every strobe the responder produces.
module tb_uart_cmd_responder;

    localparam int KWe   = 0;
    localparam int KRe   = 1;
    localparam int KTx   = 2;
    localparam int KTo   = 3;
    localparam int KDrop = 4;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       rx_perr = 1'b0;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       tx_done;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       timeout;
    logic       rx_drop;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   tx_cnt = 0;
    logic busy_hold = 1'b0;
    logic preload = 1'b1;
    logic [7:0] mem [256];
    ev_t  exp_q[$];

    uart_cmd_responder #(
        .TIMEOUT_CYCLES(8),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_perr  (rx_perr),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we   (reg_we),
        .reg_re   (reg_re),
        .reg_rdata(reg_rdata),
        .timeout  (timeout),
        .rx_drop  (rx_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: busy for four cycles after tx_en, tx_done on the last one.
    always @(posedge clk) begin
        if (rst) tx_cnt <= 0;
        else if (tx_en) tx_cnt <= 4;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end
    assign tx_busy = (tx_cnt != 0) || busy_hold;
    assign tx_done = (tx_cnt == 1);

    // Register file: read data appears exactly one cycle after reg_re.
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h22] <= 8'h5C;
            mem[8'h10] <= 8'h00;
            mem[8'h33] <= 8'h00;
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_re ? mem[reg_addr] : 8'h00;
    end

    task automatic expect_ev(input int kind, input int c, input logic [7:0] a,
                             input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.a    = a;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [7:0] a, input logic [7:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: kind %0d at cycle %0d a=%h d=%h, none required",
                     kind, cyc, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.a != a || e.d != d) begin
                errors++;
                $display("FAIL strobe: got kind %0d cyc %0d a=%h d=%h, required kind %0d cyc %0d a=%h d=%h",
                         kind, cyc, a, d, e.kind, e.cyc, e.a, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (reg_we)  check_ev(KWe, reg_addr, reg_wdata);
            if (reg_re)  check_ev(KRe, reg_addr, 8'h00);
            if (tx_en)   check_ev(KTx, 8'h00, tx_data);
            if (timeout) check_ev(KTo, 8'h00, 8'h00);
            if (rx_drop) check_ev(KDrop, 8'h00, 8'h00);
        end
    end

    task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_tx_data"}, tx_data, 8'h00);
        check_eq({tag, "_reg_addr"}, reg_addr, 8'h00);
        check_eq({tag, "_reg_wdata"}, reg_wdata, 8'h00);
        check_eq({tag, "_strobes"}, {3'b000, tx_en, reg_we, reg_re, timeout, rx_drop}, 8'h00);
    endtask

    // Called at posedge+1; returns the cycle in which rx_done was high.
    task automatic send_byte(input logic [7:0] b, input logic perr, output int n);
        rx_data = b;
        rx_perr = perr;
        rx_done = 1'b1;
        n = cyc;
        @(posedge clk);
        #1;
        rx_done = 1'b0;
        rx_perr = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        preload = 1'b0;
        check_reset_outputs("reset");
        idle(2);

        // Write 0x10 <= 0xA5
        send_byte(8'h57, 1'b0, n);
        send_byte(8'h10, 1'b0, n);
        send_byte(8'hA5, 1'b0, n);
        expect_ev(KWe, n + 1, 8'h10, 8'hA5);
        expect_ev(KTx, n + 2, 8'h00, 8'h4B);
        idle(10);

        // Read 0x22 -> 0x5C
        send_byte(8'h52, 1'b0, n);
        send_byte(8'h22, 1'b0, n);
        expect_ev(KRe, n + 1, 8'h22, 8'h00);
        expect_ev(KTx, n + 3, 8'h00, 8'h5C);
        idle(10);

        // Unknown command
        send_byte(8'h41, 1'b0, n);
        expect_ev(KTx, n + 1, 8'h00, 8'h3F);
        idle(10);

        // Parity error on the address byte
        send_byte(8'h57, 1'b0, n);
        send_byte(8'h10, 1'b1, n);
        expect_ev(KTx, n + 1, 8'h00, 8'h21);
        idle(10);

        // Timeout after eight idle cycles
        send_byte(8'h52, 1'b0, n);
        expect_ev(KTo, n + 8, 8'h00, 8'h00);
        idle(12);

        // Byte on the terminal cycle wins over the timeout
        send_byte(8'h52, 1'b0, n);
        idle(7);
        send_byte(8'h22, 1'b0, n);
        expect_ev(KRe, n + 1, 8'h22, 8'h00);
        expect_ev(KTx, n + 3, 8'h00, 8'h5C);
        idle(10);

        // Transmitter busy for 20 cycles in SEND, then a stray byte in WAIT_DONE
        busy_hold = 1'b1;
        send_byte(8'h57, 1'b0, n);
        send_byte(8'h33, 1'b0, n);
        send_byte(8'hC3, 1'b0, n);
        expect_ev(KWe, n + 1, 8'h33, 8'hC3);
        expect_ev(KTx, n + 22, 8'h00, 8'h4B);
        idle(21);
        busy_hold = 1'b0;
        idle(2);
        expect_ev(KDrop, cyc, 8'h00, 8'h00);
        send_byte(8'h99, 1'b0, n);
        idle(10);

        // Read back what was written under busy
        send_byte(8'h52, 1'b0, n);
        send_byte(8'h33, 1'b0, n);
        expect_ev(KRe, n + 1, 8'h33, 8'h00);
        expect_ev(KTx, n + 3, 8'h00, 8'hC3);
        idle(10);

        // Reset in GET_DATA, then a normal read
        send_byte(8'h57, 1'b0, n);
        send_byte(8'h10, 1'b0, n);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midreset");
        idle(2);
        send_byte(8'h52, 1'b0, n);
        send_byte(8'h10, 1'b0, n);
        expect_ev(KRe, n + 1, 8'h10, 8'h00);
        expect_ev(KTx, n + 3, 8'h00, 8'hA5);
        idle(15);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d left unseen, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
